reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised successor to the 32-entry GPR file. It is used by the dual-issue decode/writeback stages.
- Configurable data width, depth and read-port count.
- Two write ports with fixed priority.
- Write-to-read bypass on every read port.
- Optional hardwired zero register.
- A sequential clear engine that zeroes the whole array after reset or on request, so contents are deterministic without an asynchronous reset on the array.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk  in  1  clock, all state changes on posedge
rst  in  1  asynchronous active-low reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
we  in  2  write enables; bit 1 = port 1 (younger instruction)
wr_addr  in  2*ADDR_W  write addresses
wr_data  in  2*DATA_W  write data
clr_req  in  1  one-cycle pulse requesting a full-array clear
busy  out  1  clear engine active; writes are ignored while high

Behaviour:
- Reset: rst low asynchronously forces state=CLEAR, clr_idx=0, busy=1. rd_data is 0 on every port while rst is low or busy is 1.
- FSM states: IDLE, CLEAR.
  - In CLEAR, each posedge writes 0 to regs[clr_idx] and increments clr_idx.
  - On the edge that clears entry DEPTH-1, the FSM goes to IDLE and clr_idx wraps to 0.
  - busy is therefore high for exactly DEPTH posedges after rst deasserts (32 by default).
- IDLE -> CLEAR: on a posedge with clr_req=1. busy rises the following cycle and lasts DEPTH cycles.
- clr_req while in CLEAR: ignored, with no restart or extension.
- we/wr_* while busy: dropped entirely, with no queueing.
- Writes, in IDLE only, on posedge:
  - port j writes when we[j]=1, and, if ZERO_REG=1, only when addr != 0.
  - Both ports to the same address: port 1 wins and port 0 is discarded.
  - Both ports to different addresses: both are written in the same cycle.
- Read ports are combinational, zero latency, evaluated in this order:
  - 0 if rst low or busy.
  - 0 if rd_en[k]=0.
  - 0 if ZERO_REG=1 and rd_addr==0.
  - Bypass: if we[1] and wr_addr1==rd_addr, return wr_data1.
  - Otherwise, if we[0] and wr_addr0==rd_addr, return wr_data0.
  - Otherwise, return regs[rd_addr].
  - The ZERO_REG test uses each port's own rd_addr, never another port's address.
- Bypass applies only while busy=0. The returned bypass value matches exactly what the array holds after the edge, including the port-1 priority.
- With ZERO_REG=0, entry 0 behaves like any other entry: writable and bypassable.
- Width rules: no arithmetic on data. clr_idx is ADDR_W bits and wraps naturally.

Decomposition:
- Add to defines.v: rst_enable redefined as 1'b0 for this block's active-low reset, true_v/false_v, zero_v, plus local FSM state encodings ST_IDLE=1'b0 and ST_CLEAR=1'b1.
- Sub-module reg_clear_fsm (clk, rst, clr_req, busy, clr_we, clr_idx) owns the state register and index counter.
- reg_file_mp instantiates reg_clear_fsm and muxes clear writes over the user write ports when busy=1.

Test Plan:
- Reset release: hold rst low 3 cycles, release, then sample busy each cycle -> busy=1 for exactly 32 posedges, then 0; afterwards all 32 entries read 0 with rd_en=1.
- Dual write plus bypass: in IDLE, we=2'b11, addr0=3/data 0xAAAA_0001, addr1=7/data 0x5555_0002, with rd_addr port0=3 and port1=7 in the same cycle -> rd_data shows both values combinationally; next cycle, with we=0, they still read back.
- Write collision: we=2'b11, both addr=9, data0=0x1111_1111, data1=0x2222_2222 -> same-cycle bypass returns 0x2222_2222; the stored value is 0x2222_2222.
- Zero register: ZERO_REG=1, write 0xDEAD_BEEF to addr 0 on port 1 while reading addr 0 -> 0 on the same and next cycles. Re-run with ZERO_REG=0 -> 0xDEAD_BEEF.
- Clear mid-operation: fill entry 5=0x12345678, pulse clr_req, pulse clr_req again 10 cycles later, and attempt a write of 0xFFFF_FFFF to entry 6 while busy -> busy high for exactly 32 cycles from the first request; afterwards entries 5 and 6 read 0.
- Async reset mid-clear: assert rst low between edges 10 and 11 of a clear -> busy stays 1 and rd_data drops to 0 immediately. After release, busy is high for a full 32 posedges again.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared constants and clear-engine state encoding for reg_file_mp
package reg_file_mp_pkg;

  localparam logic RST_ENABLE = 1'b0;
  localparam logic TRUE_V     = 1'b1;
  localparam logic FALSE_V    = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_clear_fsm.sv
// rtl/reg_clear_fsm.sv - sequential clear engine: walks every entry once after reset or on request
module reg_clear_fsm
  import reg_file_mp_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  clr_state_e        state;
  clr_state_e        state_nxt;
  logic [ADDR_W-1:0] idx_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
    end
  end

  // The index wraps to 0 on the last entry, so a new request always starts at entry 0.
  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    busy      = FALSE_V;
    clr_we    = FALSE_V;
    case (state)
      ST_IDLE: begin
        if (clr_req) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy    = TRUE_V;
        clr_we  = TRUE_V;
        idx_nxt = clr_idx + 1'b1;
        if (&clr_idx) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - dual-write, multi-read register file with bypass and a clear engine
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [1:0]               we,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;

  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              wr0_ok, wr1_ok;

  logic              p0_en, p1_en;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_data;

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;

  reg_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign wa0 = wr_addr[0 +: ADDR_W];
  assign wa1 = wr_addr[ADDR_W +: ADDR_W];
  assign wd0 = wr_data[0 +: DATA_W];
  assign wd1 = wr_data[DATA_W +: DATA_W];

  // Port 1 is the younger instruction, so it suppresses port 0 on an address collision.
  assign wr1_ok = we[1] && !((ZERO_REG != 0) && (wa1 == '0));
  assign wr0_ok = we[0] && !((ZERO_REG != 0) && (wa0 == '0)) && !(we[1] && (wa1 == wa0));

  // The clear engine borrows write port 0; user writes are dropped while it runs.
  assign p0_en   = busy ? clr_we  : wr0_ok;
  assign p0_addr = busy ? clr_idx : wa0;
  assign p0_data = busy ? '0      : wd0;
  assign p1_en   = !busy && wr1_ok;

  always_ff @(posedge clk) begin
    if (p0_en) regs[p0_addr] <= p0_data;
    if (p1_en) regs[wa1]     <= wd1;
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      rv = '0;
      if (rst && !busy && rd_en[k] && !((ZERO_REG != 0) && (ra == '0))) begin
        if (we[1] && (wa1 == ra))      rv = wd1;
        else if (we[0] && (wa0 == ra)) rv = wd0;
        else                           rv = regs[ra];
      end
      rd_data[k*DATA_W +: DATA_W] = rv;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed vector bench for reg_file_mp with ZERO_REG=1 and ZERO_REG=0 instances
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    rd_en = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data_z, rd_data_n;
  logic [1:0]       we = '0;
  logic [2*AW-1:0]  wr_addr = '0;
  logic [2*DW-1:0]  wr_data = '0;
  logic             clr_req = 1'b0;
  logic             busy_z, busy_n;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_z),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .busy(busy_z)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .busy(busy_n)
  );

  typedef struct {
    logic [1:0]  rden;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] z0;
    logic [31:0] z1;
    logic [31:0] n0;
    logic [31:0] n1;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_rd(input logic [4:0] r0, input logic [4:0] r1);
    rd_en   = 2'b11;
    rd_addr = {r1, r0};
  endtask

  task automatic read_both(input string name, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    we = 2'b00;
    set_rd(a, a);
    #1;
    chk({name, "_z"}, rd_data_z[31:0], exp);
    chk({name, "_n"}, rd_data_n[63:32], exp);
  endtask

  initial begin
    vt[0]  = '{2'b11, 2'b11, 5'd3,  32'hAAAA_0001, 5'd7,  32'h5555_0002, 5'd3,  5'd7,
               32'hAAAA_0001, 32'h5555_0002, 32'hAAAA_0001, 32'h5555_0002};
    vt[1]  = '{2'b11, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd7,
               32'hAAAA_0001, 32'h5555_0002, 32'hAAAA_0001, 32'h5555_0002};
    vt[2]  = '{2'b11, 2'b11, 5'd9,  32'h1111_1111, 5'd9,  32'h2222_2222, 5'd9,  5'd9,
               32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222};
    vt[3]  = '{2'b11, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd9,  5'd3,
               32'h2222_2222, 32'hAAAA_0001, 32'h2222_2222, 32'hAAAA_0001};
    vt[4]  = '{2'b11, 2'b01, 5'd4,  32'hCAFE_0004, 5'd4,  32'hBADB_AD00, 5'd4,  5'd4,
               32'hCAFE_0004, 32'hCAFE_0004, 32'hCAFE_0004, 32'hCAFE_0004};
    vt[5]  = '{2'b11, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd4,  5'd7,
               32'hCAFE_0004, 32'h5555_0002, 32'hCAFE_0004, 32'h5555_0002};
    vt[6]  = '{2'b11, 2'b10, 5'd1,  32'h0,         5'd0,  32'hDEAD_BEEF, 5'd0,  5'd0,
               32'h0,         32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[7]  = '{2'b11, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd7,
               32'h0,         32'h5555_0002, 32'hDEAD_BEEF, 32'h5555_0002};
    vt[8]  = '{2'b01, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd3,
               32'hAAAA_0001, 32'h0,         32'hAAAA_0001, 32'h0};
    vt[9]  = '{2'b11, 2'b01, 5'd0,  32'h0123_4567, 5'd0,  32'h0,         5'd0,  5'd0,
               32'h0,         32'h0,         32'h0123_4567, 32'h0123_4567};
    vt[10] = '{2'b11, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd9,
               32'h0,         32'h2222_2222, 32'h0123_4567, 32'h2222_2222};
    vt[11] = '{2'b11, 2'b11, 5'd31, 32'hFFFF_0031, 5'd30, 32'hFFFF_0030, 5'd30, 5'd31,
               32'hFFFF_0030, 32'hFFFF_0031, 32'hFFFF_0030, 32'hFFFF_0031};
    vt[12] = '{2'b11, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd31, 5'd30,
               32'hFFFF_0031, 32'hFFFF_0030, 32'hFFFF_0031, 32'hFFFF_0030};

    // Reset held low for three cycles, reads forced to zero throughout.
    #1 rst = 1'b0;
    set_rd(5'd3, 5'd7);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", {31'b0, busy_z}, 32'd1);
    chk("reset_rd0", rd_data_z[31:0], 32'h0);
    chk("reset_rd1", rd_data_n[63:32], 32'h0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_z) break;
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("reset_busy_len", cnt, 32'd32);
    chk("reset_busy_n", {31'b0, busy_n}, 32'd0);

    for (int i = 0; i < 32; i++) read_both("post_reset_zero", i[4:0], 32'h0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rd_en   = vt[i].rden;
      rd_addr = {vt[i].ra1, vt[i].ra0};
      we      = vt[i].we;
      wr_addr = {vt[i].wa1, vt[i].wa0};
      wr_data = {vt[i].wd1, vt[i].wd0};
      #1;
      chk($sformatf("vec%0d_z_p0", i), rd_data_z[31:0],  vt[i].z0);
      chk($sformatf("vec%0d_z_p1", i), rd_data_z[63:32], vt[i].z1);
      chk($sformatf("vec%0d_n_p0", i), rd_data_n[31:0],  vt[i].n0);
      chk($sformatf("vec%0d_n_p1", i), rd_data_n[63:32], vt[i].n1);
    end

    // Clear mid-operation: second request and a write while busy must both be ignored.
    @(negedge clk);
    we = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h1234_5678};
    @(negedge clk);
    we = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'h6666_6666};
    read_both("pre_clear_e5", 5'd5, 32'h1234_5678);
    read_both("pre_clear_e6", 5'd6, 32'h6666_6666);
    @(negedge clk);
    clr_req = 1'b1;
    #1;
    chk("busy_before_req_edge", {31'b0, busy_z}, 32'd0);
    @(negedge clk);
    clr_req = 1'b0;
    #1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_z) break;
      cnt++;
      if (cnt == 10) begin
        clr_req = 1'b1;
        we      = 2'b01;
        wr_addr = {5'd0, 5'd6};
        wr_data = {32'h0, 32'hFFFF_FFFF};
        set_rd(5'd6, 5'd6);
        #1;
        chk("busy_no_bypass", rd_data_z[31:0], 32'h0);
      end else if (cnt == 11) begin
        clr_req = 1'b0;
        we      = 2'b00;
      end
      @(negedge clk);
      #1;
    end
    chk("clear_busy_len", cnt, 32'd32);
    read_both("post_clear_e5", 5'd5, 32'h0);
    read_both("post_clear_e6", 5'd6, 32'h0);

    // Asynchronous reset between clear edges 10 and 11 restarts the full sweep.
    @(negedge clk);
    we = 2'b01; wr_addr = {5'd0, 5'd20}; wr_data = {32'h0, 32'h2020_2020};
    read_both("pre_async_e20", 5'd20, 32'h2020_2020);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_busy", {31'b0, busy_z}, 32'd1);
    chk("async_rd", rd_data_z[31:0], 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_z) break;
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("async_busy_len", cnt, 32'd32);
    read_both("post_async_e20", 5'd20, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
